// File: rtl/nios2_c_pio_in.sv
// Avalon-MM PIO input port: synchronised DATA, IRQMASK, sticky EDGECAP, level irq; optional debounce via NIOS2_C_PIO_IN_DEBOUNCE_EN.
// Input visible in DATA two edges after it changes, captured one edge later; zero-wait-state reads, no backpressure.
module nios2_c_pio_in #(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] s1_q, s1_d, s2_q, s2_d, qd_q, qd_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d, edgecap_q, edgecap_d;
  logic [WIDTH-1:0] q_val, edge_det, wr_clr;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

`ifdef NIOS2_C_PIO_IN_DEBOUNCE_EN
  logic [WIDTH-1:0]       filt_q, filt_d;
  logic [WIDTH-1:0][15:0] cnt_q, cnt_d;

  // A bit follows s2 only once it has disagreed with the filtered value for DEBOUNCE_CYCLES cycles in a row.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == 16'(DEBOUNCE_CYCLES - 1)) begin
          filt_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      filt_q <= '0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q_val = filt_q;
`else
  logic [15:0] unused_dbc;
  assign unused_dbc = 16'(DEBOUNCE_CYCLES);
  assign q_val      = s2_q;
`endif

  always_comb begin
    case (EDGE_TYPE)
      1:       edge_det = ~q_val & qd_q;
      2:       edge_det = q_val ^ qd_q;
      default: edge_det = q_val & ~qd_q;
    endcase
  end

  always_comb begin
    wr_en     = chipselect && !write_n;
    wr_clr    = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    s1_d      = in_port;
    s2_d      = s1_q;
    qd_d      = q_val;
    irqmask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask_q;
    // A new edge overrides a simultaneous write-1-to-clear on the same bit.
    edgecap_d = (edgecap_q & ~wr_clr) | edge_det;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      qd_q      <= '0;
      irqmask_q <= '0;
      edgecap_q <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      qd_q      <= qd_d;
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = q_val;
      2'd2:    readdata[WIDTH-1:0] = irqmask_q;
      2'd3:    readdata[WIDTH-1:0] = edgecap_q;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_nios2_c_pio_in.sv
// Directed bench for nios2_c_pio_in: rising, falling and any-edge instances share one Avalon bus and input.
module tb_nios2_c_pio_in;

`ifdef NIOS2_C_PIO_IN_DEBOUNCE_EN
  localparam int DB = 16;
`else
  localparam int DB = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] rd_r, rd_f, rd_a;
  logic        irq_r, irq_f, irq_a;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nios2_c_pio_in #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_r), .irq(irq_r));

  nios2_c_pio_in #(.WIDTH(4), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(16)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_f), .irq(irq_f));

  nios2_c_pio_in #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_a), .irq(irq_a));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 4'h0;
    ticks(3);

    // Reset state
    check("rst_irq_r", {31'b0, irq_r}, 32'h0);
    check("rst_irq_a", {31'b0, irq_a}, 32'h0);
    rd(2'd0); check("rst_data", rd_r, 32'h0);
    rd(2'd2); check("rst_mask", rd_r, 32'h0);
    rd(2'd3); check("rst_ecap", rd_a, 32'h0);
    reset_n = 1'b1;
    tick();

    // DATA latency and address 1
    in_port = 4'hA;
    tick();
    rd(2'd0); check("data_early", rd_r, 32'h0);
    ticks(1 + DB);
    rd(2'd0); check("data_A", rd_r, 32'h0000000A);
    rd(2'd1); check("addr1_zero", rd_r, 32'h0);
    tick();
    rd(2'd3); check("ecap_rise_A", rd_r, 32'hA);
    rd(2'd3); check("ecap_fall_A", rd_f, 32'h0);
    rd(2'd3); check("ecap_any_A", rd_a, 32'hA);
    wr(2'd3, 32'hF);
    rd(2'd3); check("ecap_clr_all", rd_r, 32'h0);
    rd(2'd1); check("addr1_after_wr", rd_r, 32'h0);

    // Masked rising edge on bit0 raises irq on the third edge
    wr(2'd2, 32'h1);
    rd(2'd2); check("mask_1", rd_r, 32'h1);
    in_port = 4'hB;
    ticks(2 + DB);
    check("irq_not_yet", {31'b0, irq_r}, 32'h0);
    tick();
    check("irq_bit0", {31'b0, irq_r}, 32'h1);
    rd(2'd3); check("ecap_bit0", rd_r, 32'h1);
    check("irq_fall_none", {31'b0, irq_f}, 32'h0);
    wr(2'd3, 32'h1);
    rd(2'd3); check("ecap_bit0_clr", rd_r, 32'h0);
    check("irq_bit0_clr", {31'b0, irq_r}, 32'h0);

    // Per-bit write-1-to-clear
    in_port = 4'h0;
    ticks(3 + DB);
    wr(2'd3, 32'hF);
    in_port = 4'h3;
    ticks(3 + DB);
    rd(2'd3); check("ecap_3", rd_r, 32'h3);
    wr(2'd3, 32'h2);
    rd(2'd3); check("ecap_clr_bit1", rd_r, 32'h1);
    wr(2'd3, 32'h0);
    rd(2'd3); check("ecap_clr_none", rd_r, 32'h1);

    // Set beats clear when they land on the same edge
    in_port = 4'h7;
    ticks(2 + DB);
    wr(2'd3, 32'h4);
    rd(2'd3); check("ecap_set_wins", rd_r, 32'h5);
    wr(2'd3, 32'h4);
    rd(2'd3); check("ecap_bit2_clr", rd_r, 32'h1);

    // Any-edge capture with mask applied afterwards; falling capture
    wr(2'd2, 32'h0);
    wr(2'd3, 32'hF);
    in_port = 4'hF;
    ticks(3 + DB);
    rd(2'd3); check("any_bit3", rd_a, 32'h8);
    check("any_irq_masked", {31'b0, irq_a}, 32'h0);
    rd(2'd3); check("fall_on_rise", rd_f, 32'h0);
    wr(2'd2, 32'h8);
    check("any_irq_unmasked", {31'b0, irq_a}, 32'h1);
    check("rise_irq_unmasked", {31'b0, irq_r}, 32'h1);
    check("fall_irq_none", {31'b0, irq_f}, 32'h0);
    in_port = 4'h7;
    ticks(3 + DB);
    rd(2'd3); check("fall_bit3", rd_f, 32'h8);
    check("fall_irq", {31'b0, irq_f}, 32'h1);
    rd(2'd0); check("data_7", rd_a, 32'h7);

    // Reset pulse with everything set
    wr(2'd3, 32'hF);
    in_port = 4'h8;
    ticks(3 + DB);
    wr(2'd2, 32'hF);
    rd(2'd3); check("any_ecap_F", rd_a, 32'hF);
    rd(2'd3); check("fall_ecap_7", rd_f, 32'h7);
    check("any_irq_F", {31'b0, irq_a}, 32'h1);
    reset_n = 1'b0;
    tick();
    check("prst_irq_a", {31'b0, irq_a}, 32'h0);
    check("prst_irq_r", {31'b0, irq_r}, 32'h0);
    rd(2'd3); check("prst_ecap", rd_a, 32'h0);
    rd(2'd2); check("prst_mask", rd_a, 32'h0);
    rd(2'd0); check("prst_data", rd_a, 32'h0);
    reset_n = 1'b1;
    ticks(3 + DB);
    rd(2'd3); check("post_rst_rise", rd_r, 32'h8);
    check("post_rst_irq", {31'b0, irq_r}, 32'h0);
    rd(2'd0); check("post_rst_data", rd_r, 32'h8);

`ifdef NIOS2_C_PIO_IN_DEBOUNCE_EN
    // Short glitch must be filtered out
    in_port = 4'h9;
    ticks(3);
    in_port = 4'h8;
    ticks(25);
    rd(2'd0); check("glitch_data", rd_r, 32'h8);
    rd(2'd3); check("glitch_ecap", rd_r, 32'h8);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
